// File: rtl/mbank_pkg.sv
// Shared definitions for the two-port single-RAM arbiter: default widths and
// the port identifier used by the priority pointer and the read-return tag.
package mbank_pkg;
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;
endpackage

// File: rtl/mbank_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from requests and a 1-bit
// priority pointer that moves to the losing side after every grant.
module mbank_rr_arb2
  import mbank_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     req_a_i,
  input  logic     req_b_i,
  output logic     gnt_a_o,
  output logic     gnt_b_o,
  output port_id_e prio_o
);

  port_id_e prio_q;
  port_id_e prio_d;
  logic     gnt_a_s;
  logic     gnt_b_s;

  // Grant selection and next pointer; requests are ignored while in reset.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (rst) begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end else if (req_a_i && req_b_i) begin
      if (prio_q == PORT_A) begin
        gnt_a_s = 1'b1;
      end else begin
        gnt_b_s = 1'b1;
      end
    end else begin
      gnt_a_s = req_a_i;
      gnt_b_s = req_b_i;
    end

    if (gnt_a_s) begin
      prio_d = PORT_B;
    end else if (gnt_b_s) begin
      prio_d = PORT_A;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= PORT_A;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign gnt_a_o = gnt_a_s;
  assign gnt_b_o = gnt_b_s;
  assign prio_o  = prio_q;

endmodule

// File: rtl/single_port_ram.sv
// Simple synchronous single-port RAM: write on en&we, registered read data
// available the cycle after a read is sampled.
module single_port_ram #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] dout_q;

  // Storage array write and read-data register.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= din;
    end
    if (en && !we) begin
      dout_q <= mem_q[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/mbank_port_arbiter.sv
// Shares one single-port RAM between ports A and B: round-robin grant, RAM
// request muxing, and routing of read data back to the port that asked.
module mbank_port_arbiter
  import mbank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  port_id_e          prio_s;
  logic              rd_pend_q;
  logic              rd_pend_d;
  port_id_e          rd_port_q;
  port_id_e          rd_port_d;
  logic [DATA_W-1:0] a_hold_q;
  logic [DATA_W-1:0] b_hold_q;

  mbank_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_a_i (a_req),
    .req_b_i (b_req),
    .gnt_a_o (a_gnt),
    .gnt_b_o (b_gnt),
    .prio_o  (prio_s)
  );

  // RAM request mux plus tag of the read (if any) issued this cycle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    rd_pend_d = 1'b0;
    rd_port_d = PORT_A;
    if (a_gnt) begin
      ram_en    = 1'b1;
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_din   = a_wdata;
      rd_pend_d = !a_we;
      rd_port_d = PORT_A;
    end else if (b_gnt) begin
      ram_en    = 1'b1;
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_din   = b_wdata;
      rd_pend_d = !b_we;
      rd_port_d = PORT_B;
    end else begin
      ram_en    = 1'b0;
      rd_pend_d = 1'b0;
    end
  end

  // Pending-read tag; an async reset drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_port_q <= PORT_A;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  assign a_rvalid = rd_pend_q && (rd_port_q == PORT_A);
  assign b_rvalid = rd_pend_q && (rd_port_q == PORT_B);

  // Last returned data per port, shown whenever that port has no fresh read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      if (a_rvalid) begin
        a_hold_q <= ram_dout;
      end
      if (b_rvalid) begin
        b_hold_q <= ram_dout;
      end
    end
  end

  assign a_rdata = a_rvalid ? ram_dout : a_hold_q;
  assign b_rdata = b_rvalid ? ram_dout : b_hold_q;

endmodule

// File: tb/tb_mbank_port_arbiter.sv
// Directed, table-driven bench for mbank_port_arbiter driving a real
// single_port_ram; hand-written sequences cover the sweep and mid-read reset.
module tb_mbank_port_arbiter;

  typedef struct {
    logic       a_req;
    logic       a_we;
    logic [2:0] a_addr;
    logic [7:0] a_wd;
    logic       b_req;
    logic       b_we;
    logic [2:0] b_addr;
    logic [7:0] b_wd;
    logic       e_agnt;
    logic       e_bgnt;
    logic       e_arv;
    logic [7:0] e_ard;
    logic       e_brv;
    logic [7:0] e_brd;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [2:0] a_addr, b_addr, ram_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_din, ram_dout;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_en, ram_we;

  int n_pass = 0;
  int n_tot  = 0;
  vec_t tbl[17];

  mbank_port_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  single_port_ram #(.ADDR_W(3), .DATA_W(8)) u_ram (
    .clk(clk), .en(ram_en), .we(ram_we), .addr(ram_addr),
    .din(ram_din), .dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int ar, input int aw, input int aa, input int ad,
                              input int br, input int bw, input int ba, input int bd,
                              input int eag, input int ebg, input int earv, input int eard,
                              input int ebrv, input int ebrd);
    vec_t v;
    v.a_req  = ar[0];  v.a_we  = aw[0];  v.a_addr = aa[2:0]; v.a_wd = ad[7:0];
    v.b_req  = br[0];  v.b_we  = bw[0];  v.b_addr = ba[2:0]; v.b_wd = bd[7:0];
    v.e_agnt = eag[0]; v.e_bgnt = ebg[0];
    v.e_arv  = earv[0]; v.e_ard = eard[7:0];
    v.e_brv  = ebrv[0]; v.e_brd = ebrd[7:0];
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wd;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wd;
  endtask

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; a_addr = 3'd0; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 3'd0; b_wdata = 8'h00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " a_gnt"},    a_gnt,    1'b0);
    chk({tag, " b_gnt"},    b_gnt,    1'b0);
    chk({tag, " a_rvalid"}, a_rvalid, 1'b0);
    chk({tag, " b_rvalid"}, b_rvalid, 1'b0);
    chk({tag, " a_rdata"},  a_rdata,  8'h00);
    chk({tag, " b_rdata"},  b_rdata,  8'h00);
    chk({tag, " ram_en"},   ram_en,   1'b0);
    chk({tag, " ram_we"},   ram_we,   1'b0);
  endtask

  initial begin
    // Row fields: A req/we/addr/wdata, B req/we/addr/wdata, then expected
    // a_gnt, b_gnt, a_rvalid, a_rdata, b_rvalid, b_rdata.
    tbl[0]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0, 0,8'h00, 0,8'h00);
    tbl[1]  = mk(1,1,3,8'h01, 0,0,0,8'h00, 1,0, 0,8'h00, 0,8'h00);
    tbl[2]  = mk(1,0,3,8'h00, 0,0,0,8'h00, 1,0, 0,8'h00, 0,8'h00);
    tbl[3]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0, 1,8'h01, 0,8'h00);
    tbl[4]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0, 0,8'h01, 0,8'h00);
    tbl[5]  = mk(0,0,0,8'h00, 1,1,5,8'h11, 0,1, 0,8'h01, 0,8'h00);
    tbl[6]  = mk(1,1,5,8'hA5, 1,0,5,8'h00, 1,0, 0,8'h01, 0,8'h00);
    tbl[7]  = mk(0,0,0,8'h00, 1,0,5,8'h00, 0,1, 0,8'h01, 0,8'h00);
    tbl[8]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0, 0,8'h01, 1,8'hA5);
    tbl[9]  = mk(1,1,0,8'h00, 1,0,3,8'h00, 1,0, 0,8'h01, 0,8'hA5);
    tbl[10] = mk(1,1,1,8'h01, 1,0,3,8'h00, 0,1, 0,8'h01, 0,8'hA5);
    tbl[11] = mk(1,1,1,8'h01, 1,0,0,8'h00, 1,0, 0,8'h01, 1,8'h01);
    tbl[12] = mk(1,1,2,8'h02, 1,0,0,8'h00, 0,1, 0,8'h01, 0,8'h01);
    tbl[13] = mk(1,1,2,8'h02, 1,0,1,8'h00, 1,0, 0,8'h01, 1,8'h00);
    tbl[14] = mk(1,1,3,8'h03, 1,0,1,8'h00, 0,1, 0,8'h01, 0,8'h00);
    tbl[15] = mk(1,1,3,8'h03, 1,0,2,8'h00, 1,0, 0,8'h01, 1,8'h01);
    tbl[16] = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0, 0,8'h01, 0,8'h01);

    // Reset with both ports requesting: requests must be ignored.
    rst = 1'b1;
    idle();
    a_req = 1'b1; b_req = 1'b1;
    #3;
    chk_reset_vals("rst0");
    @(posedge clk); #1;
    chk_reset_vals("rst1");
    rst = 1'b0;
    idle();

    for (int r = 0; r < 17; r++) begin
      @(posedge clk); #1;
      drive(tbl[r]);
      #3;
      chk($sformatf("row%0d a_gnt", r),    a_gnt,    tbl[r].e_agnt);
      chk($sformatf("row%0d b_gnt", r),    b_gnt,    tbl[r].e_bgnt);
      chk($sformatf("row%0d a_rvalid", r), a_rvalid, tbl[r].e_arv);
      chk($sformatf("row%0d a_rdata", r),  a_rdata,  tbl[r].e_ard);
      chk($sformatf("row%0d b_rvalid", r), b_rvalid, tbl[r].e_brv);
      chk($sformatf("row%0d b_rdata", r),  b_rdata,  tbl[r].e_brd);
      chk($sformatf("row%0d ram_en", r),   ram_en,   tbl[r].e_agnt | tbl[r].e_bgnt);
      if (tbl[r].e_agnt) begin
        chk($sformatf("row%0d ram_we", r),   ram_we,   tbl[r].a_we);
        chk($sformatf("row%0d ram_addr", r), ram_addr, tbl[r].a_addr);
        chk($sformatf("row%0d ram_din", r),  ram_din,  tbl[r].a_wd);
      end else if (tbl[r].e_bgnt) begin
        chk($sformatf("row%0d ram_we", r),   ram_we,   tbl[r].b_we);
        chk($sformatf("row%0d ram_addr", r), ram_addr, tbl[r].b_addr);
        chk($sformatf("row%0d ram_din", r),  ram_din,  tbl[r].b_wd);
      end else begin
        chk($sformatf("row%0d ram_we", r),   ram_we,   1'b0);
        chk($sformatf("row%0d ram_addr", r), ram_addr, 3'd0);
        chk($sformatf("row%0d ram_din", r),  ram_din,  8'h00);
      end
    end

    // Sweep: B writes F0|i, A reads it back the next cycle.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      pat = 8'hF0 | 8'(i);
      @(posedge clk); #1;
      idle();
      b_req = 1'b1; b_we = 1'b1; b_addr = 3'(i); b_wdata = pat;
      #3;
      chk($sformatf("sweep%0d b_gnt", i), b_gnt, 1'b1);
      chk($sformatf("sweep%0d a_gnt_w", i), a_gnt, 1'b0);
      @(posedge clk); #1;
      idle();
      a_req = 1'b1; a_we = 1'b0; a_addr = 3'(i);
      #3;
      chk($sformatf("sweep%0d a_gnt", i), a_gnt, 1'b1);
      chk($sformatf("sweep%0d a_rvalid_early", i), a_rvalid, 1'b0);
      @(posedge clk); #1;
      idle();
      #3;
      chk($sformatf("sweep%0d a_rvalid", i), a_rvalid, 1'b1);
      chk($sformatf("sweep%0d a_rdata", i), a_rdata, pat);
      chk($sformatf("sweep%0d b_rvalid", i), b_rvalid, 1'b0);
    end

    // Reset lands in the cycle a read from A is granted.
    @(posedge clk); #1;
    idle();
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd2;
    #2;
    chk("mid a_gnt", a_gnt, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst0");
    @(posedge clk); #1;
    chk_reset_vals("mid_rst1");
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    #3;
    chk("post_rst a_rvalid", a_rvalid, 1'b0);
    chk("post_rst b_rvalid", b_rvalid, 1'b0);
    chk("post_rst a_rdata",  a_rdata,  8'h00);
    @(posedge clk); #1;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    #3;
    chk("post_rst both a_gnt", a_gnt, 1'b1);
    chk("post_rst both b_gnt", b_gnt, 1'b0);
    @(posedge clk); #1;
    a_req = 1'b0;
    #3;
    chk("post_rst b_gnt next", b_gnt, 1'b1);
    chk("post_rst a_rvalid next", a_rvalid, 1'b1);
    @(posedge clk); #1;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mbank_port_arbiter.md
MBANK_PORT_ARBITER -- requirements
Module: mbank_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 3, RAM address width.
REQ-002 Parameter: DATA_W, default 8, RAM data width.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 a_req  in  1  port A access request, held until a_gnt.
REQ-007 a_we  in  1  port A write (1) / read (0).
REQ-008 a_addr  in  ADDR_W  port A address.
REQ-009 a_wdata  in  DATA_W  port A write data.
REQ-010 a_gnt  out  1  port A access accepted this cycle.
REQ-011 a_rvalid  out  1  port A read data valid.
REQ-012 a_rdata  out  DATA_W  port A read data.
REQ-013 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata are identical to the a_* signals, for port B.
REQ-014 ram_en  out  1, ram_we  out  1, ram_addr  out  ADDR_W, ram_din  out  DATA_W: drive the single_port_ram en/we/addr/din.
REQ-015 ram_dout  in  DATA_W: single_port_ram read data, valid the cycle after a read is sampled.

Function
REQ-016 Grant is combinational from req and the priority state: at most one of a_gnt/b_gnt is high per cycle, and gnt is never high without its req.
REQ-017 If exactly one port requests, that port SHALL be granted in the same cycle.
REQ-018 If both ports request, the port holding priority SHALL be granted.
REQ-019 Priority state is a 1-bit round-robin pointer; after any grant it SHALL point to the non-granted port at the next edge; with no grant it holds.
REQ-020 In a granted cycle, ram_en=1 and ram_we/ram_addr/ram_din SHALL equal the winner's we/addr/wdata; otherwise ram_en=0, ram_we=0, ram_addr=0 and ram_din=0.
REQ-021 A granted read SHALL assert the winner's rvalid for exactly one cycle, the cycle after the grant, with rdata = ram_dout.
REQ-022 rdata of a port SHALL hold its last valid value while rvalid=0.
REQ-023 A granted write produces no rvalid.
REQ-024 Throughput: one RAM access per cycle; under continuous dual requests, grants SHALL strictly alternate A,B,A,B.
REQ-025 Same-address conflict: a write and a read to the same address in one cycle are serialized by priority; a read granted after the write SHALL return the new data.
REQ-026 A requester whose req stays high is granted within 2 cycles.

Reset
REQ-027 While rst=1: priority = port A; a_gnt=b_gnt=0 (req ignored); a_rvalid=b_rvalid=0; a_rdata=b_rdata=0; ram_en=ram_we=0.
REQ-028 A read granted in the cycle rst asserts SHALL NOT produce rvalid after reset release.
REQ-029 The first edge after rst deasserts SHALL arbitrate normally, with priority to A.

Structure
REQ-030 Package mbank_pkg: ADDR_W/DATA_W defaults and a port-id enum (PORT_A, PORT_B) for the priority pointer and the pending-read tag.
REQ-031 One sub-module, mbank_rr_arb2: 2-way round-robin grant logic plus pointer register; read-return tagging and RAM muxing stay in the top module.

Verification (bench instantiates single_port_ram on the ram_* ports)
REQ-032 Single port: A writes addr 3 = 0x01, then reads addr 3 -> a_gnt in the request cycles; a_rvalid one cycle later with a_rdata=0x01; b_* idle.
REQ-033 Contention: A and B both request continuously after reset (A writes addr i = i, B reads) -> grants A,B,A,B; no cycle with both gnt high.
REQ-034 Same-address: A writes addr 5 = 0xA5 and B reads addr 5 in the same cycle, with priority at A -> A granted first; B granted next; b_rvalid with b_rdata=0xA5.
REQ-035 Sweep: for i=0..7, B writes addr i = 8'hF0|i, then A reads addr i -> a_rdata=8'hF0|i each time, one cycle after grant.
REQ-036 Reset mid-read: rst asserts in the cycle a read is granted -> no rvalid after release; outputs at REQ-027 values; the next grant goes to A when both request.
